// File: rtl/avr_pkg.sv
// avr_pkg: shared constants for the AVR fetch path.
//   - 32-bit opcode mask/match pairs (JMP/CALL, LDS, STS) and a decode helper
//   - fetch FSM state encodings (S_BOOT, S_RUN, S_KILL)
//   - NOP encoding
//   - legacy pc_src encodings, kept so older avr_cpu code still compiles
package avr_pkg;

  localparam logic [15:0] NOP = 16'h0000;

  localparam logic [15:0] JMPCALL_MASK  = 16'hFE0C;
  localparam logic [15:0] JMPCALL_MATCH = 16'h940C;
  localparam logic [15:0] LDS_MASK      = 16'hFE0F;
  localparam logic [15:0] LDS_MATCH     = 16'h9000;
  localparam logic [15:0] STS_MASK      = 16'hFE0F;
  localparam logic [15:0] STS_MATCH     = 16'h9200;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t S_BOOT = 2'd0;
  localparam fetch_state_t S_RUN  = 2'd1;
  localparam fetch_state_t S_KILL = 2'd2;

  localparam logic [1:0] PC_SRC_INC   = 2'd0;
  localparam logic [1:0] PC_SRC_ABS   = 2'd1;
  localparam logic [1:0] PC_SRC_REL   = 2'd2;
  localparam logic [1:0] PC_SRC_STACK = 2'd3;

  // True when the word is the first half of a two-word instruction.
  function automatic logic is_long_op(input logic [15:0] w);
    return ((w & JMPCALL_MASK) == JMPCALL_MATCH) ||
           ((w & LDS_MASK)     == LDS_MATCH)     ||
           ((w & STS_MASK)     == STS_MATCH);
  endfunction

endpackage

// File: rtl/avr_prefetch_fifo.sv
// avr_prefetch_fifo: DEPTH-entry register queue of {pc, word}.
// Ports: CLK/RST (sync, active high), flush clears the queue, push writes
// {push_pc, push_word} at the tail, pop_n removes 0..2 entries from the head,
// count is the occupancy, head_pc/head_word read the head and next_word reads
// head+1. Flush wins over push/pop.
module avr_prefetch_fifo #(
  parameter  int ADDR_W = 16,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [15:0]       push_word,
  input  logic [1:0]        pop_n,
  output logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] head_pc,
  output logic [15:0]       head_word,
  output logic [15:0]       next_word
);

  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [ADDR_W-1:0] pc_d   [DEPTH];
  logic [15:0]       word_q [DEPTH];
  logic [15:0]       word_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, nxt_ptr;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    pc_d     = pc_q;
    word_d   = word_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d[wr_ptr_q]   = push_pc;
        word_d[wr_ptr_q] = push_word;
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      // Pointers are log2(DEPTH) wide, so the truncated add wraps naturally.
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop_n);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: it is only observed once count covers it.
  always_ff @(posedge CLK) begin
    pc_q   <= pc_d;
    word_q <= word_d;
  end

  assign nxt_ptr   = rd_ptr_q + PTR_W'(1);
  assign count     = count_q;
  assign head_pc   = pc_q[rd_ptr_q];
  assign head_word = word_q[rd_ptr_q];
  assign next_word = word_q[nxt_ptr];

endmodule

// File: rtl/avr_prefetch.sv
// avr_prefetch: prefetch queue between program ROM and avr_cpu.
// Ports: CLK, RST (sync, active high); prog_req/prog_addr/prog_data to a
// synchronous ROM (data one cycle after req); instr/instr_ext/instr_long/
// instr_pc/instr_valid/instr_ready head handshake to the CPU; redirect and
// redirect_pc flush the queue and restart fetch at an absolute target.
// Optional: define AVR_PREFETCH_LONG_INSTR_EN to present JMP/CALL/LDS/STS as
// one 32-bit transfer (instr_long/instr_ext); otherwise every word pops singly.
module avr_prefetch
  import avr_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter int                DEPTH     = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              prog_req,
  output logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_data,
  output logic [15:0]       instr,
  output logic [15:0]       instr_ext,
  output logic              instr_long,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);

`ifdef AVR_PREFETCH_LONG_INSTR_EN
  if (DEPTH < 2) begin : g_depth_chk
    $error("avr_prefetch: DEPTH must be >= 2 for long-instruction decode");
  end
`endif

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;

  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] head_pc;
  logic [15:0]       head_word, next_word;
  logic              is_long, push;
  logic [1:0]        pop_n;

  always_comb begin
`ifdef AVR_PREFETCH_LONG_INSTR_EN
    is_long = is_long_op(head_word);
`else
    is_long = 1'b0;
`endif
    // A long head waits until its second word is queued too.
    instr_valid = !RST && (is_long ? (int'(count) >= 2) : (int'(count) >= 1));
    instr       = instr_valid ? head_word : NOP;
    instr_pc    = instr_valid ? head_pc : '0;
    instr_long  = instr_valid && is_long;
    instr_ext   = instr_long ? next_word : 16'h0000;
    pop_n       = (instr_valid && instr_ready) ? (is_long ? 2'd2 : 2'd1) : 2'd0;

    // Credit counts the in-flight word so the queue can never overflow.
    prog_req  = !RST && (state_q != S_BOOT) &&
                ((int'(count) + int'(inflight_q) - int'(pop_n)) < DEPTH);
    prog_addr = fetch_pc_q;

    // In S_KILL the returning word belongs to the pre-redirect stream.
    push = inflight_q && (state_q == S_RUN) && !redirect;

    inflight_d = prog_req;
    fetch_pc_d = prog_req ? fetch_pc_q + ADDR_W'(1) : fetch_pc_q;
    state_d    = S_RUN;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      state_d    = S_KILL;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_BOOT;
      fetch_pc_q <= RESET_VEC;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
    end
  end

  avr_prefetch_fifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (redirect),
    .push      (push),
    .push_pc   (fetch_pc_q - ADDR_W'(1)),
    .push_word (prog_data),
    .pop_n     (pop_n),
    .count     (count),
    .head_pc   (head_pc),
    .head_word (head_word),
    .next_word (next_word)
  );

endmodule

// File: tb/tb_avr_prefetch.sv
module tb_avr_prefetch;

  logic        CLK = 1'b0;
  logic        RST;
  logic        prog_req;
  logic [15:0] prog_addr;
  logic [15:0] prog_data;
  logic [15:0] instr, instr_ext;
  logic        instr_long;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;

  logic        w_req;
  logic [3:0]  w_addr;
  logic [15:0] w_data;
  logic [15:0] w_instr, w_ext;
  logic        w_long;
  logic [3:0]  w_pc;
  logic        w_valid;

  logic [15:0] rom [256];

  int errors = 0;
  int checks = 0;
  int nreq;

  always #5 CLK = ~CLK;

  always_ff @(posedge CLK) prog_data <= rom[prog_addr[7:0]];
  always_ff @(posedge CLK) w_data    <= 16'hB000 | {12'h000, w_addr};

  avr_prefetch #(.ADDR_W(16), .DEPTH(4), .RESET_VEC(16'h0000)) dut (
    .CLK(CLK), .RST(RST),
    .prog_req(prog_req), .prog_addr(prog_addr), .prog_data(prog_data),
    .instr(instr), .instr_ext(instr_ext), .instr_long(instr_long),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  avr_prefetch #(.ADDR_W(4), .DEPTH(4), .RESET_VEC(4'h0)) dut_wrap (
    .CLK(CLK), .RST(RST),
    .prog_req(w_req), .prog_addr(w_addr), .prog_data(w_data),
    .instr(w_instr), .instr_ext(w_ext), .instr_long(w_long),
    .instr_pc(w_pc), .instr_valid(w_valid), .instr_ready(1'b1),
    .redirect(1'b0), .redirect_pc(4'h0)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rom_default();
    for (int i = 0; i < 256; i++) rom[i] = 16'h1000 + 16'(i);
  endtask

  // Leaves the bench in the first cycle after the last RST-high edge.
  task automatic do_reset(input logic rdy);
    RST = 1'b1;
    redirect = 1'b0;
    redirect_pc = 16'h0000;
    instr_ready = rdy;
    tick();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    // Reset fill and latency
    rom_default();
    rom[0] = 16'hE0F1; rom[1] = 16'hE0F2; rom[2] = 16'hE0F3; rom[3] = 16'hE0F4;
    do_reset(1'b1);
    check("rst_req",   32'(prog_req),    32'd0);
    check("rst_addr",  32'(prog_addr),   32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr),       32'd0);
    check("rst_pc",    32'(instr_pc),    32'd0);
    tick();
    check("c2_req",   32'(prog_req),    32'd1);
    check("c2_addr",  32'(prog_addr),   32'd0);
    check("c2_valid", 32'(instr_valid), 32'd0);
    tick();
    check("c3_valid", 32'(instr_valid), 32'd0);
    tick();
    for (int k = 0; k < 6; k++) begin
      check("fill_valid", 32'(instr_valid), 32'd1);
      check("fill_pc",    32'(instr_pc),    32'(k));
      check("fill_instr", 32'(instr),       (k < 4) ? 32'hE0F1 + 32'(k) : 32'h1000 + 32'(k));
      check("fill_long",  32'(instr_long),  32'd0);
      check("fill_ext",   32'(instr_ext),   32'd0);
      tick();
    end

    // Backpressure: four requests fill DEPTH=4, head held at pc 0
    rom_default();
    do_reset(1'b0);
    nreq = 0;
    for (int c = 1; c <= 10; c++) begin
      if (prog_req) nreq++;
      if (instr_valid) check("bp_hold_pc", 32'(instr_pc), 32'd0);
      tick();
    end
    check("bp_nreq",  32'(nreq),        32'd4);
    check("bp_req",   32'(prog_req),    32'd0);
    check("bp_valid", 32'(instr_valid), 32'd1);
    check("bp_pc",    32'(instr_pc),    32'd0);
    check("bp_instr", 32'(instr),       32'h1000);
    instr_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("bp_drain_valid", 32'(instr_valid), 32'd1);
      check("bp_drain_pc",    32'(instr_pc),    32'(k));
      check("bp_drain_instr", 32'(instr),       32'h1000 + 32'(k));
      tick();
    end

    // Redirect while the request to 0x0005 is in flight
    rom_default();
    rom[8'h40] = 16'h5A5A; rom[8'h41] = 16'h5A5B;
    do_reset(1'b1);
    repeat (6) tick();
    check("rd_req5",  32'(prog_req),  32'd1);
    check("rd_addr5", 32'(prog_addr), 32'd5);
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    check("rd_v0",    32'(instr_valid), 32'd0);
    check("rd_req",   32'(prog_req),    32'd1);
    check("rd_addr",  32'(prog_addr),   32'h40);
    tick();
    check("rd_v1",    32'(instr_valid), 32'd0);
    tick();
    check("rd_valid", 32'(instr_valid), 32'd1);
    check("rd_pc",    32'(instr_pc),    32'h40);
    check("rd_instr", 32'(instr),       32'h5A5A);
    tick();
    check("rd_pc1",    32'(instr_pc), 32'h41);
    check("rd_instr1", 32'(instr),    32'h5A5B);

    // Redirect together with a pop while count=3
    rom_default();
    rom[8'h80] = 16'h6B6B;
    do_reset(1'b0);
    repeat (5) tick();
    check("rp_pre_valid", 32'(instr_valid), 32'd1);
    check("rp_pre_pc",    32'(instr_pc),    32'd0);
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0080;
    tick();
    redirect = 1'b0;
    check("rp_v0",    32'(instr_valid), 32'd0);
    check("rp_i0",    32'(instr),       32'd0);
    tick();
    check("rp_v1",    32'(instr_valid), 32'd0);
    tick();
    check("rp_valid", 32'(instr_valid), 32'd1);
    check("rp_pc",    32'(instr_pc),    32'h80);
    check("rp_instr", 32'(instr),       32'h6B6B);

    // Two-word instruction at pc 0
    rom_default();
    rom[0] = 16'h940C; rom[1] = 16'h1234;
    do_reset(1'b1);
    repeat (3) tick();
`ifdef AVR_PREFETCH_LONG_INSTR_EN
    check("lg_wait", 32'(instr_valid), 32'd0);
    tick();
    check("lg_valid", 32'(instr_valid), 32'd1);
    check("lg_pc",    32'(instr_pc),    32'd0);
    check("lg_instr", 32'(instr),       32'h940C);
    check("lg_long",  32'(instr_long),  32'd1);
    check("lg_ext",   32'(instr_ext),   32'h1234);
    tick();
    check("lg_next_pc",   32'(instr_pc),   32'd2);
    check("lg_next_long", 32'(instr_long), 32'd0);
    check("lg_next_ins",  32'(instr),      32'h1002);
`else
    check("lg_valid", 32'(instr_valid), 32'd1);
    check("lg_pc",    32'(instr_pc),    32'd0);
    check("lg_instr", 32'(instr),       32'h940C);
    check("lg_long",  32'(instr_long),  32'd0);
    check("lg_ext",   32'(instr_ext),   32'd0);
    tick();
    check("lg_pc1",    32'(instr_pc), 32'd1);
    check("lg_instr1", 32'(instr),    32'h1234);
    tick();
    check("lg_pc2",    32'(instr_pc), 32'd2);
`endif

    // Address wrap on the 4-bit instance
    do_reset(1'b1);
    repeat (3) tick();
    for (int k = 0; k < 18; k++) begin
      check("wr_valid", 32'(w_valid), 32'd1);
      check("wr_pc",    32'(w_pc),    32'(k % 16));
      check("wr_instr", 32'(w_instr), 32'hB000 + 32'(k % 16));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
